// File: rtl/rcl_coef_driver.sv
// rcl_coef_driver: initiator-side driver for the RCL coefficient interface.
//
// Accepts one request (line a,b,c and circle m,n,k). It serialises the request onto
// coef_l_o/coef_q_o as three back-to-back in_valid_o beats: (a,m), (b,n), (c,k).
// It then waits for the RCL result and presents it on a valid/ready response port.
// The wait is bounded by TIMEOUT; on expiry the response is rsp_data_o=3 with rsp_timeout_o=1.
//
// Ports
//   clk_i, rst_i              clock (rising edge), asynchronous active-high reset
//   req_valid_i/req_ready_o   request handshake
//   req_{a,b,c,m,n}_i         signed 5-bit coefficients
//   req_k_i                   unsigned 5-bit squared radius
//   in_valid_o                coefficient beat valid to the RCL
//   coef_l_o, coef_q_o        coefficient beats to the RCL
//   rcl_out_valid_i           result pulse from the RCL
//   rcl_out_i                 result from the RCL: 0 separate, 1 tangent, 2 intersect
//   rsp_valid_o/rsp_ready_i   response handshake
//   rsp_data_o, rsp_timeout_o response payload
//   err_spurious_o            sticky: RCL result seen while not waiting for one
module rcl_coef_driver #(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned GAP_CYC = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       req_valid_i,
  output logic       req_ready_o,
  input  logic [4:0] req_a_i,
  input  logic [4:0] req_b_i,
  input  logic [4:0] req_c_i,
  input  logic [4:0] req_m_i,
  input  logic [4:0] req_n_i,
  input  logic [4:0] req_k_i,
  output logic       in_valid_o,
  output logic [4:0] coef_l_o,
  output logic [4:0] coef_q_o,
  input  logic       rcl_out_valid_i,
  input  logic [1:0] rcl_out_i,
  output logic       rsp_valid_o,
  input  logic       rsp_ready_i,
  output logic [1:0] rsp_data_o,
  output logic       rsp_timeout_o,
  output logic       err_spurious_o
);

  localparam int unsigned GapW  = (GAP_CYC > 1) ? $clog2(GAP_CYC + 1) : 1;
  localparam int unsigned WaitW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    StGap,
    StIdle,
    StSend0,
    StSend1,
    StSend2,
    StWait,
    StResp
  } state_e;

  state_e             state_q, state_d;
  logic [GapW-1:0]    gap_q, gap_d;
  logic [WaitW-1:0]   wait_q, wait_d;
  // a and m go straight into the first beat, so only the later beats are held.
  logic [4:0]         b_q, b_d, c_q, c_d, n_q, n_d, k_q, k_d;
  logic               req_ready_q, req_ready_d;
  logic               in_valid_q, in_valid_d;
  logic [4:0]         coef_l_q, coef_l_d, coef_q_q, coef_q_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [1:0]         rsp_data_q, rsp_data_d;
  logic               rsp_timeout_q, rsp_timeout_d;
  logic               err_q, err_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= StGap;
      gap_q         <= GapW'(GAP_CYC);
      wait_q        <= '0;
      b_q           <= '0;
      c_q           <= '0;
      n_q           <= '0;
      k_q           <= '0;
      req_ready_q   <= 1'b0;
      in_valid_q    <= 1'b0;
      coef_l_q      <= '0;
      coef_q_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_timeout_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      gap_q         <= gap_d;
      wait_q        <= wait_d;
      b_q           <= b_d;
      c_q           <= c_d;
      n_q           <= n_d;
      k_q           <= k_d;
      req_ready_q   <= req_ready_d;
      in_valid_q    <= in_valid_d;
      coef_l_q      <= coef_l_d;
      coef_q_q      <= coef_q_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_timeout_q <= rsp_timeout_d;
      err_q         <= err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    gap_d         = gap_q;
    wait_d        = wait_q;
    b_d           = b_q;
    c_d           = c_q;
    n_d           = n_q;
    k_d           = k_q;
    req_ready_d   = req_ready_q;
    in_valid_d    = in_valid_q;
    coef_l_d      = coef_l_q;
    coef_q_d      = coef_q_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_data_d    = rsp_data_q;
    rsp_timeout_d = rsp_timeout_q;
    err_d         = err_q | (rcl_out_valid_i && (state_q != StWait));

    unique case (state_q)
      StGap: begin
        req_ready_d = 1'b0;
        // Leave on the edge where the counter reaches 0 so req_ready is low for GAP_CYC edges.
        if (gap_q <= GapW'(1)) begin
          gap_d       = '0;
          req_ready_d = 1'b1;
          state_d     = StIdle;
        end else begin
          gap_d = gap_q - GapW'(1);
        end
      end
      StIdle: begin
        if (req_valid_i && req_ready_q) begin
          b_d         = req_b_i;
          c_d         = req_c_i;
          n_d         = req_n_i;
          k_d         = req_k_i;
          coef_l_d    = req_a_i;
          coef_q_d    = req_m_i;
          in_valid_d  = 1'b1;
          req_ready_d = 1'b0;
          state_d     = StSend0;
        end
      end
      StSend0: begin
        coef_l_d = b_q;
        coef_q_d = n_q;
        state_d  = StSend1;
      end
      StSend1: begin
        coef_l_d = c_q;
        coef_q_d = k_q;
        state_d  = StSend2;
      end
      StSend2: begin
        in_valid_d = 1'b0;
        coef_l_d   = '0;
        coef_q_d   = '0;
        wait_d     = '0;
        state_d    = StWait;
      end
      StWait: begin
        // A result arriving on the expiry cycle takes priority over the timeout.
        if (rcl_out_valid_i) begin
          rsp_data_d    = rcl_out_i;
          rsp_timeout_d = 1'b0;
          rsp_valid_d   = 1'b1;
          state_d       = StResp;
        end else if (wait_q == WaitW'(TIMEOUT - 1)) begin
          rsp_data_d    = 2'd3;
          rsp_timeout_d = 1'b1;
          rsp_valid_d   = 1'b1;
          state_d       = StResp;
        end else begin
          wait_d = wait_q + WaitW'(1);
        end
      end
      StResp: begin
        if (rsp_valid_q && rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          gap_d       = GapW'(GAP_CYC);
          state_d     = StGap;
        end
      end
      default: begin
        state_d = StGap;
      end
    endcase
  end

  assign req_ready_o    = req_ready_q;
  assign in_valid_o     = in_valid_q;
  assign coef_l_o       = coef_l_q;
  assign coef_q_o       = coef_q_q;
  assign rsp_valid_o    = rsp_valid_q;
  assign rsp_data_o     = rsp_data_q;
  assign rsp_timeout_o  = rsp_timeout_q;
  assign err_spurious_o = err_q;

endmodule

// File: tb/tb_rcl_coef_driver.sv
// Directed bench for rcl_coef_driver with a small behavioural RCL model.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_rcl_coef_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [4:0] req_a, req_b, req_c, req_m, req_n, req_k;
  logic       in_valid;
  logic [4:0] coef_L, coef_Q;
  logic       rcl_out_valid;
  logic [1:0] rcl_out;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [1:0] rsp_data;
  logic       rsp_timeout;
  logic       err_spurious;

  logic       model_valid;
  logic [1:0] model_out;
  logic       spur_valid;
  logic       rcl_en;

  int n_checks = 0;
  int n_pass   = 0;
  int lat;

  always #5 clk = ~clk;

  assign rcl_out_valid = model_valid | spur_valid;
  assign rcl_out       = model_out;

  rcl_coef_driver #(
    .TIMEOUT(15),
    .GAP_CYC(2)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_a_i        (req_a),
    .req_b_i        (req_b),
    .req_c_i        (req_c),
    .req_m_i        (req_m),
    .req_n_i        (req_n),
    .req_k_i        (req_k),
    .in_valid_o     (in_valid),
    .coef_l_o       (coef_L),
    .coef_q_o       (coef_Q),
    .rcl_out_valid_i(rcl_out_valid),
    .rcl_out_i      (rcl_out),
    .rsp_valid_o    (rsp_valid),
    .rsp_ready_i    (rsp_ready),
    .rsp_data_o     (rsp_data),
    .rsp_timeout_o  (rsp_timeout),
    .err_spurious_o (err_spurious)
  );

  // Geometric relation: compare (am+bn+c)^2 against k(a^2+b^2).
  function automatic logic [1:0] relation(input logic [4:0] a, input logic [4:0] b,
                                          input logic [4:0] c, input logic [4:0] m,
                                          input logic [4:0] n, input logic [4:0] k);
    int av, bv, cv, mv, nv, kv, d, lhs, rhs;
    av  = int'($signed(a));
    bv  = int'($signed(b));
    cv  = int'($signed(c));
    mv  = int'($signed(m));
    nv  = int'($signed(n));
    kv  = int'(k);
    d   = av * mv + bv * nv + cv;
    lhs = d * d;
    rhs = kv * (av * av + bv * bv);
    if (lhs > rhs) return 2'd0;
    else if (lhs == rhs) return 2'd1;
    else return 2'd2;
  endfunction

  // RCL model: result pulse 8 cycles after the last beat, when enabled.
  initial begin : rcl_model
    logic [4:0] ml [3];
    logic [4:0] mq [3];
    int         mbeat;
    int         mdly;
    logic [1:0] mrel;
    model_valid = 1'b0;
    model_out   = 2'd0;
    mbeat       = 0;
    mdly        = 0;
    mrel        = 2'd0;
    forever begin
      @(negedge clk);
      model_valid = 1'b0;
      if (rst) begin
        mbeat = 0;
        mdly  = 0;
      end else begin
        if (mdly > 0) begin
          mdly--;
          if (mdly == 0) begin
            model_valid = 1'b1;
            model_out   = mrel;
          end
        end
        if (in_valid) begin
          ml[mbeat] = coef_L;
          mq[mbeat] = coef_Q;
          mbeat++;
          if (mbeat == 3) begin
            mbeat = 0;
            mrel  = relation(ml[0], ml[1], ml[2], mq[0], mq[1], mq[2]);
            if (rcl_en) mdly = 8;
          end
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Issue a request and check the three beats plus the return to idle levels.
  task automatic send_req(input string tag, input logic [4:0] a, input logic [4:0] b,
                          input logic [4:0] c, input logic [4:0] m, input logic [4:0] n,
                          input logic [4:0] k);
    chk({tag, "_ready_before"}, req_ready, 1);
    req_a = a; req_b = b; req_c = c; req_m = m; req_n = n; req_k = k;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    chk({tag, "_b0_valid"}, in_valid, 1);
    chk({tag, "_b0_L"}, coef_L, a);
    chk({tag, "_b0_Q"}, coef_Q, m);
    chk({tag, "_b0_ready"}, req_ready, 0);
    @(negedge clk);
    chk({tag, "_b1_valid"}, in_valid, 1);
    chk({tag, "_b1_L"}, coef_L, b);
    chk({tag, "_b1_Q"}, coef_Q, n);
    @(negedge clk);
    chk({tag, "_b2_valid"}, in_valid, 1);
    chk({tag, "_b2_L"}, coef_L, c);
    chk({tag, "_b2_Q"}, coef_Q, k);
    @(negedge clk);
    chk({tag, "_post_valid"}, in_valid, 0);
    chk({tag, "_post_L"}, coef_L, 0);
    chk({tag, "_post_Q"}, coef_Q, 0);
  endtask

  // Bounded wait for rsp_valid; cyc returns falling edges waited since WAIT was entered.
  task automatic wait_rsp(input string tag, input int limit, output int cyc);
    cyc = 0;
    while (rsp_valid !== 1'b1 && cyc < limit) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_rsp_seen"}, rsp_valid, 1);
  endtask

  task automatic handshake(input string tag);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({tag, "_hs_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_hs_gap0_ready"}, req_ready, 0);
    @(negedge clk);
    chk({tag, "_hs_gap1_ready"}, req_ready, 0);
    @(negedge clk);
    chk({tag, "_hs_idle_ready"}, req_ready, 1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_a      = '0; req_b = '0; req_c = '0; req_m = '0; req_n = '0; req_k = '0;
    rsp_ready  = 1'b0;
    spur_valid = 1'b0;
    rcl_en     = 1'b1;

    // Reset values and gap after release.
    @(negedge clk);
    @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_in_valid", in_valid, 0);
    chk("rst_coef_L", coef_L, 0);
    chk("rst_coef_Q", coef_Q, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_timeout", rsp_timeout, 0);
    chk("rst_err", err_spurious, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("gap1_ready", req_ready, 0);
    chk("gap1_in_valid", in_valid, 0);
    chk("gap1_rsp_valid", rsp_valid, 0);
    @(negedge clk);
    chk("gap2_ready", req_ready, 1);
    chk("gap2_in_valid", in_valid, 0);

    // Tangent: line x=0, circle centre (3,0), r^2=9.
    send_req("tan", 5'd1, 5'd0, 5'd0, 5'd3, 5'd0, 5'd9);
    wait_rsp("tan", 40, lat);
    chk("tan_latency", lat, 8);
    chk("tan_data", rsp_data, 1);
    chk("tan_timeout", rsp_timeout, 0);
    handshake("tan");

    // Separate, negative a; consumer stalls 5 cycles.
    send_req("sep", 5'b11111, 5'd0, 5'd0, 5'd5, 5'd0, 5'd4);
    wait_rsp("sep", 40, lat);
    chk("sep_data", rsp_data, 0);
    chk("sep_timeout", rsp_timeout, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("stall%0d_valid", i), rsp_valid, 1);
      chk($sformatf("stall%0d_data", i), rsp_data, 0);
    end
    handshake("sep");

    // Silent RCL: timeout 15 cycles after entering WAIT.
    rcl_en = 1'b0;
    send_req("tmo", 5'd0, 5'd1, 5'd0, 5'd0, 5'd1, 5'd4);
    wait_rsp("tmo", 40, lat);
    chk("tmo_latency", lat, 15);
    chk("tmo_data", rsp_data, 3);
    chk("tmo_timeout", rsp_timeout, 1);
    handshake("tmo");
    chk("tmo_data_kept", rsp_data, 3);
    chk("tmo_flag_kept", rsp_timeout, 1);
    rcl_en = 1'b1;

    // Reset during SEND1.
    req_a = 5'd2; req_b = 5'd3; req_c = 5'd4; req_m = 5'd5; req_n = 5'd6; req_k = 5'd7;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("abort_b1_valid", in_valid, 1);
    chk("abort_b1_L", coef_L, 3);
    rst = 1'b1;
    #1;
    chk("abort_in_valid", in_valid, 0);
    chk("abort_coef_L", coef_L, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_gap_ready", req_ready, 0);
    @(negedge clk);
    chk("abort_idle_ready", req_ready, 1);
    repeat (12) @(negedge clk);
    chk("abort_no_rsp", rsp_valid, 0);
    chk("abort_no_err", err_spurious, 0);

    // Back-to-back requests after recovery.
    send_req("int", 5'd0, 5'd1, 5'd0, 5'd0, 5'd1, 5'd4);
    wait_rsp("int", 40, lat);
    chk("int_data", rsp_data, 2);
    chk("int_timeout", rsp_timeout, 0);
    handshake("int");
    send_req("tan2", 5'd1, 5'd1, 5'b11110, 5'd0, 5'd0, 5'd2);
    wait_rsp("tan2", 40, lat);
    chk("tan2_data", rsp_data, 1);
    chk("tan2_timeout", rsp_timeout, 0);
    handshake("tan2");

    // Spurious result in IDLE: ignored for data, sticky error until reset.
    chk("spur_err_before", err_spurious, 0);
    spur_valid = 1'b1;
    @(negedge clk);
    spur_valid = 1'b0;
    chk("spur_err_set", err_spurious, 1);
    chk("spur_no_rsp", rsp_valid, 0);
    chk("spur_still_idle", req_ready, 1);
    repeat (4) @(negedge clk);
    chk("spur_err_sticky", err_spurious, 1);
    rst = 1'b1;
    #1;
    chk("spur_err_cleared", err_spurious, 0);
    @(negedge clk);
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
